// File: rtl/wave_shaper.sv
// wave_shaper: phase index to amplitude-scaled PCM via a small output FIFO; define WAVE_DITHER_EN for LFSR dither
module wave_shaper #(
  parameter int PHASE_W = 10,
  parameter int DATA_W = 16,
  parameter int AMP_W = 8,
  parameter int FIFO_DEPTH = 2,
  parameter logic [15:0] DITHER_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic [1:0]         wave_sel,
  input  logic [PHASE_W-1:0] pulse_width,
  input  logic [AMP_W-1:0]   amplitude,
  output logic [DATA_W-1:0]  sample_data,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               wrap_pulse,
  output logic               overflow,
  input  logic               overflow_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] MAX_P = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MAX_N = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [PHASE_W-1:0] PW_RST = {1'b1, {(PHASE_W-1){1'b0}}};
  logic [PHASE_W-1:0] phase_q, pw_q, pw_d;
  logic [1:0] sel_q, sel_d;
  logic [PHASE_W-2:0] tri_t;
  logic [DATA_W-1:0] saw, raw_d, raw_q, scaled, s2_d, s2_q, last_q, last_d;
  logic signed [DATA_W+AMP_W-1:0] prod;
  logic evt, wrap, s1_v_q, s2_v_q, wrap_q, overflow_q, overflow_d;
  logic pop, push, full, drop;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    evt = en && phase_in != phase_q;
    wrap = evt && phase_in < phase_q;
    sel_d = wrap ? wave_sel : sel_q;
    pw_d = wrap ? pulse_width : pw_q;
    saw = {~phase_in[PHASE_W-1], phase_in[PHASE_W-2:0], {(DATA_W-PHASE_W){1'b0}}};
    tri_t = phase_in[PHASE_W-1] ? ~phase_in[PHASE_W-2:0] : phase_in[PHASE_W-2:0];
    raw_d = sel_d == 2'b00 ? saw :
            sel_d == 2'b11 ? ~saw :
            sel_d == 2'b01 ? {~tri_t[PHASE_W-2], tri_t[PHASE_W-3:0], {(DATA_W-PHASE_W+1){1'b0}}} :
            phase_in < pw_d ? MAX_P : MAX_N;
    prod = $signed({{AMP_W{raw_q[DATA_W-1]}}, raw_q}) * $signed({{DATA_W{1'b0}}, amplitude});
    scaled = DATA_W'(prod >>> AMP_W);
  end
`ifdef WAVE_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb begin
    s2_d = (lfsr_q[0] && scaled != MAX_P) ? scaled + {{(DATA_W-1){1'b0}}, 1'b1} : scaled;
    lfsr_d = s1_v_q ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000)) : lfsr_q;
  end
  always_ff @(posedge clk) lfsr_q <= rst ? DITHER_SEED : lfsr_d;
`else
  always_comb s2_d = scaled;
`endif
  // A write into a full FIFO still lands when the head pops on the same edge
  always_comb begin
    sample_valid = cnt_q != '0;
    sample_data = sample_valid ? mem_q[rd_q] : last_q;
    full = cnt_q == DEPTH;
    pop = sample_valid && sample_ready;
    push = s2_v_q && (!full || pop);
    drop = s2_v_q && full && !pop;
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = (push && !pop) ? cnt_q + (AW+1)'(1) : (pop && !push) ? cnt_q - (AW+1)'(1) : cnt_q;
    last_d = pop ? mem_q[rd_q] : last_q;
    overflow_d = drop || (overflow_q && !overflow_clr);
    wrap_pulse = wrap_q;
    overflow = overflow_q;
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s2_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      sel_q <= '0;
      pw_q <= PW_RST;
      raw_q <= '0;
      s1_v_q <= 1'b0;
      s2_q <= '0;
      s2_v_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      last_q <= '0;
      wrap_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      phase_q <= phase_in;
      sel_q <= sel_d;
      pw_q <= pw_d;
      raw_q <= raw_d;
      s1_v_q <= evt;
      s2_q <= s2_d;
      s2_v_q <= s1_v_q;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      wrap_q <= wrap;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_wave_shaper.sv
// tb_wave_shaper: scoreboard bench for wave_shaper in its default build
module tb_wave_shaper;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sample_ready = 1'b1, overflow_clr = 1'b0;
  logic [9:0] phase_in = '0, pulse_width = 10'd512;
  logic [1:0] wave_sel = '0;
  logic [7:0] amplitude = 8'd255;
  logic [15:0] sample_data;
  logic sample_valid, wrap_pulse, overflow;
  int checks = 0, failures = 0;
  int exp_q[$];
  int prev_p = 0, act_sel = 0, act_pw = 512;
  always #5 clk = ~clk;
  wave_shaper dut (
    .clk(clk), .rst(rst), .en(en), .phase_in(phase_in), .wave_sel(wave_sel),
    .pulse_width(pulse_width), .amplitude(amplitude), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .wrap_pulse(wrap_pulse),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );
  task automatic check(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int shape(int p, int sel, int pw, int amp);
    int raw, t, prod;
    t = p < 512 ? p : 1023 - p;
    raw = sel == 0 ? p * 64 - 32768 : sel == 3 ? 32767 - p * 64 :
          sel == 1 ? t * 128 - 32768 : (p < pw ? 32767 : -32768);
    prod = raw * amp;
    return prod >= 0 ? prod / 256 : -((255 - prod) / 256);
  endfunction
  task automatic drive(int p);
    @(posedge clk); #1;
    phase_in = 10'(p);
    if (en && p != prev_p) begin
      if (p < prev_p) begin
        act_sel = int'(wave_sel);
        act_pw = int'(pulse_width);
      end
      exp_q.push_back(shape(p, act_sel, act_pw, int'(amplitude)));
    end
    prev_p = p;
  endtask
  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst && sample_valid && sample_ready) begin
      check("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("sample", $signed(sample_data), exp_q.pop_front());
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", sample_valid, 0);
    check("rst_data", $signed(sample_data), 0);
    check("rst_wrap", wrap_pulse, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    en = 1'b1;
    // saw, consecutive phases, 3-edge latency
    drive(1000);
    cycles(5);
    drive(0); drive(1); drive(2);
    @(negedge clk); check("lat_pre", sample_valid, 0);
    @(negedge clk); check("lat_first", sample_valid, 1);
    repeat (3) @(negedge clk);
    check("lat_drain", sample_valid, 0);
    check("t1_sb", exp_q.size(), 0);
    // triangle peak, held phase gives no more samples
    amplitude = 8'd128;
    wave_sel = 2'b01;
    drive(1000); drive(5); drive(511); drive(512);
    cycles(8);
    check("t2_sb", exp_q.size(), 0);
    check("t2_idle", sample_valid, 0);
    // pulse, config change deferred to the next wrap
    amplitude = 8'd255;
    wave_sel = 2'b10;
    pulse_width = 10'd100;
    drive(900); drive(50);
    @(negedge clk); check("wrap_pre", wrap_pulse, 0);
    @(negedge clk); check("wrap_hi", wrap_pulse, 1);
    @(negedge clk); check("wrap_lo", wrap_pulse, 0);
    drive(99); drive(100);
    wave_sel = 2'b00;
    drive(300); drive(1023); drive(0);
    cycles(8);
    check("t3_sb", exp_q.size(), 0);
    // en=0 suppresses events and wrap
    wave_sel = 2'b11;
    en = 1'b0;
    drive(700); drive(5);
    @(negedge clk); @(negedge clk);
    check("en0_wrap", wrap_pulse, 0);
    cycles(3);
    check("en0_valid", sample_valid, 0);
    en = 1'b1;
    wave_sel = 2'b00;
    drive(10);
    cycles(6);
    check("en1_sb", exp_q.size(), 0);
    // backpressure and overflow
    sample_ready = 1'b0;
    drive(100); drive(200); drive(300); drive(400);
    cycles(4);
    check("t4_valid", sample_valid, 1);
    check("t4_ovf", overflow, 1);
    check("t4_head", $signed(sample_data), exp_q[0]);
    cycles(2);
    check("t4_hold", $signed(sample_data), exp_q[0]);
    exp_q.delete(3);
    exp_q.delete(2);
    overflow_clr = 1'b1;
    cycles(1);
    overflow_clr = 1'b0;
    check("t4_clr", overflow, 0);
    drive(500);
    cycles(2);
    overflow_clr = 1'b1;
    cycles(1);
    overflow_clr = 1'b0;
    check("t4_clr_drop", overflow, 1);
    exp_q.delete(2);
    overflow_clr = 1'b1;
    cycles(1);
    overflow_clr = 1'b0;
    sample_ready = 1'b1;
    cycles(4);
    check("t4_sb", exp_q.size(), 0);
    // full FIFO: write and pop on the same edge
    sample_ready = 1'b0;
    drive(600); drive(700);
    cycles(4);
    drive(800);
    cycles(2);
    sample_ready = 1'b1;
    cycles(1);
    sample_ready = 1'b0;
    check("t5_ovf", overflow, 0);
    check("t5_head", $signed(sample_data), exp_q[0]);
    sample_ready = 1'b1;
    cycles(4);
    check("t5_sb", exp_q.size(), 0);
    // reset with FIFO full and pipeline busy
    sample_ready = 1'b0;
    drive(850); drive(900); drive(950);
    cycles(4);
    check("t6_ovf_pre", overflow, 1);
    drive(980); drive(990);
    cycles(1);
    rst = 1'b1;
    phase_in = '0;
    cycles(1);
    check("t6_valid", sample_valid, 0);
    check("t6_ovf", overflow, 0);
    check("t6_data", $signed(sample_data), 0);
    rst = 1'b0;
    exp_q.delete();
    prev_p = 0;
    act_sel = 0;
    act_pw = 512;
    sample_ready = 1'b1;
    cycles(3);
    check("t6_quiet", sample_valid, 0);
    drive(600);
    cycles(6);
    check("t6_sb", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
